// File: rtl/sargantana_icache_pkg.sv
// Shared icache types and default geometry for the flush controller and the clearing counter.
package sargantana_icache_pkg;

    localparam int unsigned ICACHE_DEPTH_DEFAULT  = 64;
    localparam int unsigned ICACHE_WAYS_DEFAULT   = 4;
    localparam int unsigned DRAIN_TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        FLUSH,
        DONE
    } flush_state_t;

endpackage

// File: rtl/sargantana_icache_flush_ctrl_if.sv
// Link between the flush controller and the set-clearing counter.
interface sargantana_icache_flush_ctrl_if #(
    parameter int unsigned ICACHE_DEPTH = 64
);
    localparam int unsigned ADDR_WIDHT = $clog2(ICACHE_DEPTH);

    logic                  flush_enable;
    logic                  flush_done;
    logic [ADDR_WIDHT-1:0] flush_addr;

    modport master (
        output flush_enable,
        input  flush_done,
        input  flush_addr
    );

    modport slave (
        input  flush_enable,
        output flush_done,
        output flush_addr
    );

endinterface

// File: rtl/sargantana_cleaning_module.sv
// Set-clearing counter: walks 0..ICACHE_DEPTH-1 while enabled and wraps back to 0.
module sargantana_cleaning_module
    import sargantana_icache_pkg::*;
#(
    parameter  int unsigned ICACHE_DEPTH = ICACHE_DEPTH_DEFAULT,
    localparam int unsigned ADDR_WIDHT   = $clog2(ICACHE_DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  flush_enable_i,
    output logic                  flush_done_o,
    output logic [ADDR_WIDHT-1:0] addr_q
);

    localparam logic [ADDR_WIDHT-1:0] LastSet = ADDR_WIDHT'(ICACHE_DEPTH - 1);

    // Power-of-two depth lets the increment wrap to 0 on its own.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            addr_q <= '0;
        end else if (flush_enable_i) begin
            addr_q <= addr_q + ADDR_WIDHT'(1);
        end
    end

    assign flush_done_o = (addr_q == LastSet);

endmodule

// File: rtl/sargantana_icache_flush_ctrl.sv
// Icache flush controller: drains refills, sweeps valid bits via the clearing counter, acks the core.
module sargantana_icache_flush_ctrl
    import sargantana_icache_pkg::*;
#(
    parameter  int unsigned ICACHE_DEPTH  = ICACHE_DEPTH_DEFAULT,
    parameter  int unsigned ICACHE_WAYS   = ICACHE_WAYS_DEFAULT,
    parameter  int unsigned DRAIN_TIMEOUT = DRAIN_TIMEOUT_DEFAULT,
    localparam int unsigned ADDR_WIDHT    = $clog2(ICACHE_DEPTH),
    localparam int unsigned TO_WIDTH      = $clog2(DRAIN_TIMEOUT + 1)
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   flush_req_i,
    output logic                   flush_ack_o,
    output logic                   busy_o,
    output logic                   lookup_block_o,
    input  logic                   refill_busy_i,
    output logic                   refill_kill_o,
    sargantana_icache_flush_ctrl_if.master cnt_if,
    output logic [ICACHE_WAYS-1:0] vbit_clr_we_o,
    output logic [ADDR_WIDHT-1:0]  vbit_clr_addr_o
);

    localparam logic [TO_WIDTH-1:0] DrainLast = TO_WIDTH'(DRAIN_TIMEOUT - 1);

    flush_state_t        state_q, state_d;
    logic                pending_q, pending_d;
    logic                flush_first_q, flush_first_d;
    logic [TO_WIDTH-1:0] drain_cnt_q, drain_cnt_d;
    logic                drain_timeout;

    assign drain_timeout = (state_q == DRAIN) && (drain_cnt_q == DrainLast);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q       <= IDLE;
            pending_q     <= 1'b0;
            flush_first_q <= 1'b0;
            drain_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            flush_first_q <= flush_first_d;
            drain_cnt_q   <= drain_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        drain_cnt_d = drain_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (flush_req_i || pending_q) begin
                    state_d   = refill_busy_i ? DRAIN : FLUSH;
                    pending_d = 1'b0;
                end
            end
            DRAIN: begin
                if (!refill_busy_i || drain_timeout) begin
                    state_d     = FLUSH;
                    drain_cnt_d = '0;
                end else begin
                    drain_cnt_d = drain_cnt_q + TO_WIDTH'(1);
                end
            end
            FLUSH: begin
                // A request after set 0 was cleared could miss lines already swept.
                if (flush_req_i && !flush_first_q) begin
                    pending_d = 1'b1;
                end
                if (cnt_if.flush_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (flush_req_i || pending_q) begin
                    state_d   = refill_busy_i ? DRAIN : FLUSH;
                    pending_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        flush_first_d = (state_d == FLUSH) && (state_q != FLUSH);
    end

    always_comb begin
        flush_ack_o         = (state_q == DONE);
        busy_o              = (state_q != IDLE);
        lookup_block_o      = (state_q != IDLE);
        refill_kill_o       = drain_timeout && refill_busy_i;
        cnt_if.flush_enable = (state_q == FLUSH);
        vbit_clr_we_o       = {ICACHE_WAYS{state_q == FLUSH}};
        vbit_clr_addr_o     = cnt_if.flush_addr;
    end

endmodule

// File: tb/tb_sargantana_icache_flush_ctrl.sv
// Bench: two controller+counter pairs (64 sets / 2 sets) against a sweep-level reference model.
module tb_sargantana_icache_flush_ctrl;

    localparam int unsigned DA   = 64;
    localparam int unsigned DB   = 2;
    localparam int unsigned W    = 4;
    localparam int unsigned TOA  = 255;
    localparam int unsigned TOB  = 8;

    logic clk = 1'b0;
    logic rstn, req, rbusy;

    always #5 clk = ~clk;

    logic         a_ack, a_busy, a_blk, a_kill;
    logic [W-1:0] a_we;
    logic [5:0]   a_addr;
    logic         b_ack, b_busy, b_blk, b_kill;
    logic [W-1:0] b_we;
    logic [0:0]   b_addr;

    sargantana_icache_flush_ctrl_if #(.ICACHE_DEPTH(DA)) if_a ();
    sargantana_icache_flush_ctrl_if #(.ICACHE_DEPTH(DB)) if_b ();

    sargantana_icache_flush_ctrl #(.ICACHE_DEPTH(DA), .ICACHE_WAYS(W), .DRAIN_TIMEOUT(TOA)) dut_a (
        .clk_i(clk), .rstn_i(rstn), .flush_req_i(req), .flush_ack_o(a_ack), .busy_o(a_busy),
        .lookup_block_o(a_blk), .refill_busy_i(rbusy), .refill_kill_o(a_kill), .cnt_if(if_a),
        .vbit_clr_we_o(a_we), .vbit_clr_addr_o(a_addr)
    );
    sargantana_cleaning_module #(.ICACHE_DEPTH(DA)) cnt_a (
        .clk_i(clk), .rstn_i(rstn), .flush_enable_i(if_a.flush_enable),
        .flush_done_o(if_a.flush_done), .addr_q(if_a.flush_addr)
    );

    sargantana_icache_flush_ctrl #(.ICACHE_DEPTH(DB), .ICACHE_WAYS(W), .DRAIN_TIMEOUT(TOB)) dut_b (
        .clk_i(clk), .rstn_i(rstn), .flush_req_i(req), .flush_ack_o(b_ack), .busy_o(b_busy),
        .lookup_block_o(b_blk), .refill_busy_i(rbusy), .refill_kill_o(b_kill), .cnt_if(if_b),
        .vbit_clr_we_o(b_we), .vbit_clr_addr_o(b_addr)
    );
    sargantana_cleaning_module #(.ICACHE_DEPTH(DB)) cnt_b (
        .clk_i(clk), .rstn_i(rstn), .flush_enable_i(if_b.flush_enable),
        .flush_done_o(if_b.flush_done), .addr_q(if_b.flush_addr)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: drain cycles spent (-1 = not draining), set being cleared (-1 = no sweep).
    int m_drain [2];
    int m_set   [2];
    bit m_ack   [2];
    bit m_pend  [2];
    int depth   [2] = '{DA, DB};
    int tmo     [2] = '{TOA, TOB};

    int cyc, n_we_a, n_ack_a, n_kill_a, ack_cyc_a, first_we_a;
    int n_ack_b, n_kill_b, kill_cyc_b, first_we_b;

    task automatic chk(input int inst, input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL inst%0d %s: observed %0h expected %0h", inst, tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_drain[i] = -1;
            m_set[i]   = -1;
            m_ack[i]   = 1'b0;
            m_pend[i]  = 1'b0;
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < 2; i++) begin
            logic        e_busy, e_kill, e_en;
            logic [31:0] e_addr;
            e_busy = (m_drain[i] >= 0) || (m_set[i] >= 0) || m_ack[i];
            e_kill = (m_drain[i] >= 0) && rbusy && (m_drain[i] == tmo[i] - 1);
            e_en   = (m_set[i] >= 0);
            e_addr = e_en ? m_set[i] : 0;
            if (i == 0) begin
                chk(i, "busy", 32'(a_busy), 32'(e_busy));
                chk(i, "lookup_block", 32'(a_blk), 32'(e_busy));
                chk(i, "ack", 32'(a_ack), 32'(m_ack[i]));
                chk(i, "kill", 32'(a_kill), 32'(e_kill));
                chk(i, "flush_enable", 32'(if_a.flush_enable), 32'(e_en));
                chk(i, "clr_we", 32'(a_we), e_en ? 32'hF : 32'h0);
                chk(i, "clr_addr", 32'(a_addr), e_addr);
            end else begin
                chk(i, "busy", 32'(b_busy), 32'(e_busy));
                chk(i, "lookup_block", 32'(b_blk), 32'(e_busy));
                chk(i, "ack", 32'(b_ack), 32'(m_ack[i]));
                chk(i, "kill", 32'(b_kill), 32'(e_kill));
                chk(i, "flush_enable", 32'(if_b.flush_enable), 32'(e_en));
                chk(i, "clr_we", 32'(b_we), e_en ? 32'hF : 32'h0);
                chk(i, "clr_addr", 32'(b_addr), e_addr);
            end
        end
    endtask

    task automatic model_step();
        if (!rstn) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 2; i++) begin
            bit go = 1'b0;
            if (m_drain[i] >= 0) begin
                if (!rbusy || m_drain[i] == tmo[i] - 1) begin
                    m_drain[i] = -1;
                    m_set[i]   = 0;
                end else begin
                    m_drain[i]++;
                end
            end else if (m_set[i] >= 0) begin
                if (req && m_set[i] != 0) m_pend[i] = 1'b1;
                if (m_set[i] == depth[i] - 1) begin
                    m_set[i] = -1;
                    m_ack[i] = 1'b1;
                end else begin
                    m_set[i]++;
                end
            end else if (m_ack[i]) begin
                m_ack[i] = 1'b0;
                if (req || m_pend[i]) begin
                    m_pend[i] = 1'b0;
                    go = 1'b1;
                end
            end else if (req || m_pend[i]) begin
                m_pend[i] = 1'b0;
                go = 1'b1;
            end
            if (go) begin
                if (rbusy) m_drain[i] = 0;
                else       m_set[i]   = 0;
            end
        end
    endtask

    task automatic clr_stats();
        cyc = 0; n_we_a = 0; n_ack_a = 0; n_kill_a = 0; ack_cyc_a = -1; first_we_a = -1;
        n_ack_b = 0; n_kill_b = 0; kill_cyc_b = -1; first_we_b = -1;
    endtask

    // Inputs are already driven at the falling edge; sample, advance model, move to next falling edge.
    task automatic cycle();
        #1;
        check_outputs();
        if (a_we != 0) begin
            n_we_a++;
            if (first_we_a < 0) first_we_a = cyc;
        end
        if (a_ack) begin
            n_ack_a++;
            ack_cyc_a = cyc;
        end
        if (a_kill) n_kill_a++;
        if (b_we != 0 && first_we_b < 0) first_we_b = cyc;
        if (b_ack) n_ack_b++;
        if (b_kill) begin
            n_kill_b++;
            kill_cyc_b = cyc;
        end
        cyc++;
        model_step();
        @(negedge clk);
    endtask

    initial begin
        rstn = 1'b0; req = 1'b0; rbusy = 1'b0;
        model_reset();
        clr_stats();
        cycle();
        rstn = 1'b1;
        repeat (3) cycle();

        // Idle flush: request with no refill, one 64-set sweep, ack 65 cycles after the request.
        clr_stats();
        req = 1'b1; cycle(); req = 1'b0;
        repeat (70) cycle();
        chk(0, "idle_writes", n_we_a, 64);
        chk(0, "idle_first_write", first_we_a, 1);
        chk(0, "idle_ack_count", n_ack_a, 1);
        chk(0, "idle_ack_cycle", ack_cyc_a, 65);
        chk(0, "idle_busy_after", 32'(a_busy), 0);

        // Drain: refill busy for 10 cycles; the 8-cycle-timeout instance kills on its 8th DRAIN cycle.
        clr_stats();
        rbusy = 1'b1; req = 1'b1; cycle(); req = 1'b0;
        repeat (9) cycle();
        rbusy = 1'b0;
        repeat (70) cycle();
        chk(0, "drain_first_write", first_we_a, 11);
        chk(0, "drain_writes", n_we_a, 64);
        chk(0, "drain_kill_count", n_kill_a, 0);
        chk(1, "timeout_kill_count", n_kill_b, 1);
        chk(1, "timeout_kill_cycle", kill_cyc_b, 8);
        chk(1, "timeout_first_write", first_we_b, 9);

        // Coalescing into the current operation: requests in DRAIN and in FLUSH cycle 0.
        clr_stats();
        rbusy = 1'b1; req = 1'b1; cycle();
        cycle();
        rbusy = 1'b0; req = 1'b0; cycle();
        req = 1'b1; cycle(); req = 1'b0;
        repeat (70) cycle();
        chk(0, "merge_ack_count", n_ack_a, 1);
        chk(0, "merge_writes", n_we_a, 64);
        chk(1, "merge_ack_count", n_ack_b, 1);

        // Pending: requests in FLUSH cycles 30 and 40 collapse into one extra back-to-back sweep.
        clr_stats();
        req = 1'b1; cycle(); req = 1'b0;
        repeat (30) cycle();
        req = 1'b1; cycle(); req = 1'b0;
        repeat (9) cycle();
        req = 1'b1; cycle(); req = 1'b0;
        repeat (140) cycle();
        chk(0, "pend_ack_count", n_ack_a, 2);
        chk(0, "pend_writes", n_we_a, 128);
        chk(0, "pend_last_ack", ack_cyc_a, 130);

        // Asynchronous reset at FLUSH cycle 20, between clock edges.
        clr_stats();
        req = 1'b1; cycle(); req = 1'b0;
        repeat (20) cycle();
        #2 rstn = 1'b0;
        #1;
        chk(0, "rst_busy", 32'(a_busy), 0);
        chk(0, "rst_we", 32'(a_we), 0);
        chk(0, "rst_enable", 32'(if_a.flush_enable), 0);
        chk(0, "rst_addr", 32'(a_addr), 0);
        model_reset();
        check_outputs();
        @(negedge clk);
        repeat (2) cycle();
        rstn = 1'b1;
        clr_stats();
        repeat (70) cycle();
        chk(0, "rst_no_ack", n_ack_a, 0);
        chk(0, "rst_no_write", n_we_a, 0);

        // Random requests and refill activity.
        repeat (1500) begin
            req = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) rbusy = ~rbusy;
            cycle();
        end
        req = 1'b0; rbusy = 1'b0;
        repeat (150) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
